spatz_strbreq_merge_window_ctrl: RTL and testbench

// Sequencer in front of the partial-write merge tree on the VFU ports of the Spatz cluster.

---
 rtl/spatz_pkg.sv | 12 +
 rtl/spatz_credit_counter.sv | 63 ++++++
 rtl/spatz_strbreq_merge_window_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_spatz_strbreq_merge_window_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spatz_pkg.sv
// Shared types for the Spatz VFU request path.
// Contents:
//   merge_win_state_e : state of the partial-write merge window sequencer.
package spatz_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RELEASE = 2'd2
    } merge_win_state_e;

endpackage : spatz_pkg

// File: rtl/spatz_credit_counter.sv
// Multi-increment / multi-decrement credit counter.
// Each cycle the count moves by popcount(inc_i) - popcount(dec_i). Both are
// applied in the same cycle. A net decrement below zero saturates at zero and
// trips an assertion, because it means a response arrived with no request in
// flight.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   inc_i        : one bit per port, request accepted downstream this cycle
//   dec_i        : one bit per port, response retired this cycle
//   count_o      : current count (registered)
module spatz_credit_counter #(
    parameter int unsigned NumPorts = 8,
    parameter int unsigned MaxCnt   = 16,
    localparam int unsigned CntW    = $clog2(MaxCnt + 1),
    localparam int unsigned PopW    = $clog2(NumPorts + 1),
    localparam int unsigned SumW    = CntW + PopW
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumPorts-1:0] inc_i,
    input  logic [NumPorts-1:0] dec_i,
    output logic [CntW-1:0]     count_o
);

    function automatic logic [PopW-1:0] popcount(input logic [NumPorts-1:0] v);
        logic [PopW-1:0] c;
        c = '0;
        for (int i = 0; i < NumPorts; i++) begin
            c = c + PopW'(v[i]);
        end
        return c;
    endfunction

    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;
    logic [PopW-1:0] inc_cnt;
    logic [PopW-1:0] dec_cnt;
    logic [SumW-1:0] up_sum;
    logic            underflow;

    always_comb begin
        inc_cnt   = popcount(inc_i);
        dec_cnt   = popcount(dec_i);
        // Add first in a wider width so the increment is never lost before
        // the decrement is taken off.
        up_sum    = SumW'(count_q) + SumW'(inc_cnt);
        underflow = (SumW'(dec_cnt) > up_sum);
        count_d   = underflow ? '0 : CntW'(up_sum - SumW'(dec_cnt));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

    underflow_chk : assert property (@(posedge clk_i) disable iff (rst_i) !underflow);

endmodule : spatz_credit_counter

// File: rtl/spatz_strbreq_merge_window_ctrl.sv
// Merge-window sequencer in front of the partial-write merge tree.
// Partial-strobe writes are held for a programmable window so that peers to
// the same line reach the tree together, then released as one group. Reads
// and full-strobe writes bypass the window. An outstanding-credit counter
// bounds the number of requests in flight.
//
// Handshake: fwd_valid_o[i] is a request into the merge tree; a transfer
// happens only on fwd_valid_o[i] & fwd_ready_i[i], and req_ready_o[i] mirrors
// exactly that transfer back to the VFU port with zero latency. Once a port
// has been presented, its valid stays high until the transfer, regardless of
// credit changes. Responses retire on rsp_valid_i[i] & rsp_ready_i[i].
//
// Ports:
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   cfg_enable_i      : 1 windows partial writes, 0 passes them through
//   cfg_max_wait_i    : collect window length in cycles, sampled on window open
//   req_valid_i/req_write_i/req_full_strb_i : per-port request attributes
//   req_ready_o       : per-port ready back to the VFU
//   fwd_valid_o/fwd_ready_i : per-port handshake into the merge tree
//   rsp_valid_i/rsp_ready_i : per-port response handshake (credit return)
//   outstanding_o     : current credit count
//   busy_o            : sequencer is not IDLE (registered)
//   stat_windows_o    : number of released windows, wrapping
module spatz_strbreq_merge_window_ctrl
    import spatz_pkg::*;
#(
    parameter int unsigned MergeNum          = 8,
    parameter int unsigned MaxWait           = 7,
    parameter int unsigned NumOutstandingMem = 16,
    localparam int unsigned CntW  = $clog2(NumOutstandingMem + 1),
    localparam int unsigned WaitW = $clog2(MaxWait + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cfg_enable_i,
    input  logic [WaitW-1:0]    cfg_max_wait_i,
    input  logic [MergeNum-1:0] req_valid_i,
    input  logic [MergeNum-1:0] req_write_i,
    input  logic [MergeNum-1:0] req_full_strb_i,
    output logic [MergeNum-1:0] req_ready_o,
    output logic [MergeNum-1:0] fwd_valid_o,
    input  logic [MergeNum-1:0] fwd_ready_i,
    input  logic [MergeNum-1:0] rsp_valid_i,
    input  logic [MergeNum-1:0] rsp_ready_i,
    output logic [CntW-1:0]     outstanding_o,
    output logic                busy_o,
    output logic [31:0]         stat_windows_o
);

    // Presenting a full group of MergeNum ports from this level can never
    // push the count past NumOutstandingMem.
    localparam int unsigned CreditLimit = NumOutstandingMem - MergeNum;

    merge_win_state_e    state_q;
    logic                busy_q;
    logic [WaitW-1:0]    wait_q;
    logic [WaitW-1:0]    max_wait_q;
    logic [MergeNum-1:0] rel_mask_q;
    logic [MergeNum-1:0] rel_done_q;
    logic                rel_go_q;
    logic [MergeNum-1:0] presented_q;
    logic [31:0]         stat_q;

    logic [CntW-1:0]     outstanding_q;
    logic                credit_ok;
    logic [MergeNum-1:0] partial;
    logic [MergeNum-1:0] partial_free;
    logic                pass_partial;
    logic [MergeNum-1:0] new_pres;
    logic                rel_launch;
    logic [MergeNum-1:0] rel_pres;
    logic [MergeNum-1:0] rel_hs;
    logic                rel_all_done;
    logic [MergeNum-1:0] fwd_valid;
    logic [MergeNum-1:0] fwd_hs;
    logic [MergeNum-1:0] rsp_hs;
    logic                collect_exit;
    logic [WaitW-1:0]    max_wait_clamped;

    always_comb begin
        credit_ok    = (outstanding_q <= CntW'(CreditLimit));
        partial      = req_valid_i & req_write_i & ~req_full_strb_i;
        // A partial already presented in pass-through mode is owned by the
        // presented path until it transfers; it must not join a window.
        partial_free = partial & ~presented_q;
        pass_partial = (state_q == IDLE) && !cfg_enable_i;

        new_pres = '0;
        if (credit_ok) begin
            new_pres = req_valid_i & ~presented_q & (~partial | {MergeNum{pass_partial}});
        end

        // The group's credit check happens once; after launch the group
        // stays presented even if the count rises in the meantime.
        rel_launch = (state_q == RELEASE) && (rel_go_q || credit_ok);
        rel_pres   = rel_launch ? (rel_mask_q & ~rel_done_q) : '0;

        // Async reset forces every output low immediately, even mid-cycle.
        fwd_valid    = rst_i ? '0 : (presented_q | new_pres | rel_pres);
        fwd_hs       = fwd_valid & fwd_ready_i;
        rel_hs       = rel_pres & fwd_ready_i;
        rsp_hs       = rsp_valid_i & rsp_ready_i;
        rel_all_done = ((rel_done_q | rel_hs) == rel_mask_q);

        collect_exit = (&partial) || (wait_q == max_wait_q) || !cfg_enable_i;

        if (32'(cfg_max_wait_i) > MaxWait) begin
            max_wait_clamped = WaitW'(MaxWait);
        end else begin
            max_wait_clamped = cfg_max_wait_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            wait_q      <= '0;
            max_wait_q  <= '0;
            rel_mask_q  <= '0;
            rel_done_q  <= '0;
            rel_go_q    <= 1'b0;
            presented_q <= '0;
            stat_q      <= '0;
        end else begin
            presented_q <= (presented_q | new_pres) & ~fwd_hs;
            case (state_q)
                IDLE: begin
                    if (cfg_enable_i && (|partial_free)) begin
                        state_q    <= COLLECT;
                        busy_q     <= 1'b1;
                        wait_q     <= '0;
                        max_wait_q <= max_wait_clamped;
                    end
                end
                COLLECT: begin
                    if (collect_exit) begin
                        rel_mask_q <= partial_free;
                        rel_done_q <= '0;
                        rel_go_q   <= 1'b0;
                        // Requests withdrawn during the window leave nothing
                        // to release; that does not count as a window.
                        if (|partial_free) begin
                            state_q <= RELEASE;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        wait_q <= wait_q + WaitW'(1);
                    end
                end
                RELEASE: begin
                    if (rel_launch) begin
                        rel_go_q <= 1'b1;
                    end
                    rel_done_q <= rel_done_q | rel_hs;
                    if (rel_all_done) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        stat_q     <= stat_q + 32'd1;
                        rel_mask_q <= '0;
                        rel_done_q <= '0;
                        rel_go_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    spatz_credit_counter #(
        .NumPorts (MergeNum),
        .MaxCnt   (NumOutstandingMem)
    ) i_credit (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (fwd_hs),
        .dec_i   (rsp_hs),
        .count_o (outstanding_q)
    );

    assign fwd_valid_o    = fwd_valid;
    assign req_ready_o    = fwd_hs;
    assign outstanding_o  = outstanding_q;
    assign busy_o         = busy_q;
    assign stat_windows_o = stat_q;

endmodule : spatz_strbreq_merge_window_ctrl

// File: tb/tb_spatz_strbreq_merge_window_ctrl.sv
// Bench for spatz_strbreq_merge_window_ctrl: a table of pass-through vectors
// plus hand-written sequences for windows, credit limits and reset.
module tb_spatz_strbreq_merge_window_ctrl;

    localparam int N = 8;

    logic       clk;
    logic       rst;
    logic       cfg_enable;
    logic [2:0] cfg_max_wait;
    logic [N-1:0] req_valid, req_write, req_full, req_ready;
    logic [N-1:0] fwd_valid, fwd_ready, rsp_valid, rsp_ready;
    logic [4:0]   outstanding;
    logic         busy;
    logic [31:0]  stat;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] v;
        logic [7:0] w;
        logic [7:0] f;
        logic [7:0] fr;
        logic [7:0] rv;
        logic [7:0] exp_fwd;
        logic [4:0] exp_cnt;
    } vec_t;

    vec_t tbl[11];
    logic [15:0] exp_q[$];

    spatz_strbreq_merge_window_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cfg_enable_i    (cfg_enable),
        .cfg_max_wait_i  (cfg_max_wait),
        .req_valid_i     (req_valid),
        .req_write_i     (req_write),
        .req_full_strb_i (req_full),
        .req_ready_o     (req_ready),
        .fwd_valid_o     (fwd_valid),
        .fwd_ready_i     (fwd_ready),
        .rsp_valid_i     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .outstanding_o   (outstanding),
        .busy_o          (busy),
        .stat_windows_o  (stat)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver tasks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs just after the falling edge; comb outputs settle by +2.
    task automatic cyc(input logic [7:0] v, input logic [7:0] w, input logic [7:0] f,
                       input logic [7:0] fr, input logic [7:0] rv);
        @(negedge clk);
        req_valid = v;
        req_write = w;
        req_full  = f;
        fwd_ready = fr;
        rsp_valid = rv;
        #2;
    endtask

    // Registered outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n, input logic [7:0] rv);
        for (int i = 0; i < n; i++) begin
            cyc(8'h00, 8'h00, 8'h00, 8'hFF, rv);
            tick();
        end
    endtask

    initial begin
        logic [15:0] e;
        int cnt;

        tbl[0]  = '{8'h08, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h08, 5'd1};
        tbl[1]  = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'h08, 8'h00, 5'd0};
        tbl[2]  = '{8'hFF, 8'h0F, 8'h00, 8'hFF, 8'h00, 8'hFF, 5'd8};
        tbl[3]  = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 5'd0};
        tbl[4]  = '{8'h33, 8'h33, 8'h11, 8'h0F, 8'h00, 8'h33, 5'd2};
        tbl[5]  = '{8'h30, 8'h30, 8'h10, 8'hF0, 8'h00, 8'h30, 5'd4};
        tbl[6]  = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'h33, 8'h00, 5'd0};
        tbl[7]  = '{8'h81, 8'h80, 8'h80, 8'h80, 8'h00, 8'h81, 5'd1};
        tbl[8]  = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h80, 8'h01, 5'd0};
        tbl[9]  = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 5'd1};
        tbl[10] = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'h01, 8'h00, 5'd0};

        rst          = 1'b1;
        cfg_enable   = 1'b0;
        cfg_max_wait = 3'd0;
        req_valid    = '0;
        req_write    = '0;
        req_full     = '0;
        fwd_ready    = '0;
        rsp_valid    = '0;
        rsp_ready    = 8'hFF;
        #1;
        check("reset_fwd_valid", 32'(fwd_valid), 32'h0);
        check("reset_req_ready", 32'(req_ready), 32'h0);
        check("reset_outstanding", 32'(outstanding), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_stat", stat, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Pass-through table (windowing off)
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].v, tbl[i].w, tbl[i].f, tbl[i].fr, tbl[i].rv);
            exp_q.push_back({tbl[i].exp_fwd, 3'b000, tbl[i].exp_cnt});
            e = exp_q.pop_front();
            check($sformatf("tbl%0d_fwd_valid", i), 32'(fwd_valid), 32'(e[15:8]));
            check($sformatf("tbl%0d_req_ready", i), 32'(req_ready), 32'(e[15:8] & tbl[i].fr));
            tick();
            check($sformatf("tbl%0d_outstanding", i), 32'(outstanding), 32'(e[4:0]));
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'h0);
        end

        // Window: ports 0,2 at t0, port 5 joins at t1, max_wait 3
        cfg_enable   = 1'b1;
        cfg_max_wait = 3'd3;
        for (int t = 0; t < 6; t++) begin
            if (t == 0) cyc(8'h05, 8'h05, 8'h00, 8'hFF, 8'h00);
            else        cyc(8'h25, 8'h25, 8'h00, 8'hFF, 8'h00);
            check($sformatf("win_t%0d_fwd_valid", t), 32'(fwd_valid), (t == 5) ? 32'h25 : 32'h0);
            if (t >= 1) check($sformatf("win_t%0d_busy", t), 32'(busy), 32'h1);
            tick();
        end
        check("win_stat", stat, 32'd1);
        check("win_outstanding", 32'(outstanding), 32'd3);
        idle_cycles(1, 8'h25);
        check("win_busy_after", 32'(busy), 32'h0);
        check("win_drain", 32'(outstanding), 32'd0);

        // All ports partial: release right after COLLECT entry
        cfg_max_wait = 3'd7;
        for (int t = 0; t < 3; t++) begin
            cyc(8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00);
            check($sformatf("all_t%0d_fwd_valid", t), 32'(fwd_valid), (t == 2) ? 32'hFF : 32'h0);
            tick();
        end
        check("all_stat", stat, 32'd2);
        check("all_outstanding", 32'(outstanding), 32'd8);
        idle_cycles(1, 8'hFF);
        check("all_drain", 32'(outstanding), 32'd0);

        // Credit limit: reads on port 0 with responses blocked
        cfg_enable = 1'b0;
        rsp_ready  = 8'h00;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(8'h01, 8'h00, 8'h00, 8'h01, 8'h00);
            exp_q.push_back({(cnt <= 8) ? 8'h01 : 8'h00, 3'b000, 5'((cnt <= 8) ? cnt + 1 : cnt)});
            e = exp_q.pop_front();
            check($sformatf("cred%0d_fwd_valid", k), 32'(fwd_valid), 32'(e[15:8]));
            tick();
            check($sformatf("cred%0d_outstanding", k), 32'(outstanding), 32'(e[4:0]));
            cnt = int'(e[4:0]);
        end
        rsp_ready = 8'h01;
        cyc(8'h01, 8'h00, 8'h00, 8'h01, 8'h01);
        check("cred_blocked_fwd_valid", 32'(fwd_valid), 32'h0);
        tick();
        check("cred_after_rsp", 32'(outstanding), 32'd8);
        cyc(8'h01, 8'h00, 8'h00, 8'h01, 8'h00);
        check("cred_resume_fwd_valid", 32'(fwd_valid), 32'h01);
        tick();
        check("cred_resume_outstanding", 32'(outstanding), 32'd9);
        rsp_ready = 8'hFF;
        idle_cycles(9, 8'h01);
        check("cred_drain", 32'(outstanding), 32'd0);

        // Held partial during RELEASE opens a second window
        cfg_enable   = 1'b1;
        cfg_max_wait = 3'd0;
        cyc(8'h01, 8'h01, 8'h00, 8'h00, 8'h00);
        check("hold_t0_fwd_valid", 32'(fwd_valid), 32'h0);
        tick();
        cyc(8'h01, 8'h01, 8'h00, 8'h00, 8'h00);
        check("hold_t1_fwd_valid", 32'(fwd_valid), 32'h0);
        tick();
        cyc(8'h11, 8'h11, 8'h00, 8'h00, 8'h00);
        check("hold_t2_fwd_valid", 32'(fwd_valid), 32'h01);
        tick();
        cyc(8'h11, 8'h11, 8'h00, 8'h00, 8'h00);
        check("hold_t3_fwd_valid", 32'(fwd_valid), 32'h01);
        check("hold_t3_busy", 32'(busy), 32'h1);
        tick();
        cyc(8'h11, 8'h11, 8'h00, 8'h01, 8'h00);
        check("hold_t4_req_ready", 32'(req_ready), 32'h01);
        tick();
        check("hold_stat1", stat, 32'd3);
        cyc(8'h10, 8'h10, 8'h00, 8'hFF, 8'h00);
        check("hold_t5_fwd_valid", 32'(fwd_valid), 32'h0);
        check("hold_t5_busy", 32'(busy), 32'h0);
        tick();
        cyc(8'h10, 8'h10, 8'h00, 8'hFF, 8'h00);
        check("hold_t6_busy", 32'(busy), 32'h1);
        tick();
        cyc(8'h10, 8'h10, 8'h00, 8'hFF, 8'h00);
        check("hold_t7_fwd_valid", 32'(fwd_valid), 32'h10);
        tick();
        check("hold_stat2", stat, 32'd4);
        check("hold_outstanding", 32'(outstanding), 32'd2);
        idle_cycles(1, 8'h11);
        check("hold_drain", 32'(outstanding), 32'd0);

        // Reset in the middle of a window
        cfg_max_wait = 3'd7;
        cyc(8'h42, 8'h02, 8'h00, 8'h40, 8'h00);
        check("rst_t0_fwd_valid", 32'(fwd_valid), 32'h40);
        tick();
        cyc(8'h42, 8'h02, 8'h00, 8'h40, 8'h00);
        check("rst_t1_busy", 32'(busy), 32'h1);
        check("rst_t1_req_ready", 32'(req_ready), 32'h40);
        rst = 1'b1;
        #1;
        check("rst_async_fwd_valid", 32'(fwd_valid), 32'h0);
        check("rst_async_req_ready", 32'(req_ready), 32'h0);
        check("rst_async_busy", 32'(busy), 32'h0);
        check("rst_async_outstanding", 32'(outstanding), 32'h0);
        check("rst_async_stat", stat, 32'h0);
        @(negedge clk);
        req_valid = '0;
        req_write = '0;
        rst = 1'b0;
        tick();
        check("rst_after_busy", 32'(busy), 32'h0);
        check("rst_after_outstanding", 32'(outstanding), 32'h0);
        cfg_enable = 1'b0;
        cyc(8'h04, 8'h00, 8'h00, 8'h04, 8'h00);
        check("rst_after_fwd_valid", 32'(fwd_valid), 32'h04);
        tick();
        check("rst_after_count", 32'(outstanding), 32'd1);
        idle_cycles(1, 8'h04);
        check("rst_after_drain", 32'(outstanding), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_spatz_strbreq_merge_window_ctrl
